// File: rtl/tea_pkg.sv
// ---------------------------------------------------------------------------
// Module : tea_pkg
// Brief  : Register map, control codes and host FSM states for the TEA core.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tea_pkg;

  localparam logic [2:0] TEA_ADDR_DATA = 3'd0;
  localparam logic [2:0] TEA_ADDR_KLO  = 3'd1;
  localparam logic [2:0] TEA_ADDR_KHI  = 3'd2;
  localparam logic [2:0] TEA_ADDR_CTRL = 3'd3;
  localparam logic [2:0] TEA_ADDR_RES  = 3'd4;

  localparam logic [1:0] TEA_CMD_ENC = 2'd1;
  localparam logic [1:0] TEA_CMD_DEC = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CRST = 4'd1,
    ST_WDAT = 4'd2,
    ST_WKLO = 4'd3,
    ST_WKHI = 4'd4,
    ST_WCTL = 4'd5,
    ST_WAIT = 4'd6,
    ST_RADR = 4'd7,
    ST_RCAP = 4'd8,
    ST_OUT  = 4'd9
  } tea_host_state_t;

endpackage

`default_nettype wire

// File: rtl/tea_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// Module : tea_host_ctrl_if
// Brief  : Block streams and TEA core register bus seen by the host controller.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tea_host_ctrl_if #(
  parameter int WORD_SIZE = 64
);

  logic                   i_in_valid;
  logic                   o_in_ready;
  logic [WORD_SIZE-1:0]   i_in_data;
  logic                   i_in_mode;
  logic [2*WORD_SIZE-1:0] i_key;
  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [WORD_SIZE-1:0]   o_out_data;
  logic                   o_tea_rstn;
  logic [2:0]             o_tea_addr;
  logic [WORD_SIZE-1:0]   o_tea_data;
  logic                   o_tea_we;
  logic [WORD_SIZE-1:0]   i_tea_data;
  logic                   i_tea_ready;
  logic                   o_busy;
  logic                   o_err;

  // master = the host controller, slave = stream fabric plus TEA core
  modport master (
    input  i_in_valid, i_in_data, i_in_mode, i_key, i_out_ready,
    input  i_tea_data, i_tea_ready,
    output o_in_ready, o_out_valid, o_out_data,
    output o_tea_rstn, o_tea_addr, o_tea_data, o_tea_we, o_busy, o_err
  );

  modport slave (
    output i_in_valid, i_in_data, i_in_mode, i_key, i_out_ready,
    output i_tea_data, i_tea_ready,
    input  o_in_ready, o_out_valid, o_out_data,
    input  o_tea_rstn, o_tea_addr, o_tea_data, o_tea_we, o_busy, o_err
  );

endinterface

`default_nettype wire

// File: rtl/tea_host_ctrl.sv
// ---------------------------------------------------------------------------
// Module : tea_host_ctrl
// Brief  : Drives one TEA core per input block: reset, program, wait, read.
//          Optional watchdog enabled by defining TEA_HOST_TIMEOUT_EN.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tea_host_ctrl
  import tea_pkg::*;
#(
  parameter int WORD_SIZE      = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  tea_host_ctrl_if.master  bus
);

  tea_host_state_t        r_state;
  tea_host_state_t        w_state_nxt;

  logic [WORD_SIZE-1:0]   r_blk;
  logic [2*WORD_SIZE-1:0] r_key;
  logic                   r_mode;

  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [WORD_SIZE-1:0]   r_out_data;
  logic                   r_tea_rstn;
  logic [2:0]             r_tea_addr;
  logic [WORD_SIZE-1:0]   r_tea_data;
  logic                   r_tea_we;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_timeout;
  logic                   w_tea_rstn;
  logic [2:0]             w_tea_addr;
  logic [WORD_SIZE-1:0]   w_tea_data;
  logic                   w_tea_we;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: if (r_in_ready && bus.i_in_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_CRST;
      end
      ST_CRST: w_state_nxt = ST_WDAT;
      ST_WDAT: w_state_nxt = ST_WKLO;
      ST_WKLO: w_state_nxt = ST_WKHI;
      ST_WKHI: w_state_nxt = ST_WCTL;
      ST_WCTL: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_tea_ready)
          w_state_nxt = ST_RADR;
        else if (w_timeout)
          w_state_nxt = ST_IDLE;
      end
      ST_RADR: w_state_nxt = ST_RCAP;
      ST_RCAP: w_state_nxt = ST_OUT;
      ST_OUT:  if (bus.i_out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    w_tea_rstn = 1'b1;
    w_tea_we   = 1'b0;
    w_tea_addr = r_tea_addr;
    w_tea_data = r_tea_data;
    case (w_state_nxt)
      ST_CRST: w_tea_rstn = 1'b0;
      ST_WDAT: begin
        w_tea_we   = 1'b1;
        w_tea_addr = TEA_ADDR_DATA;
        w_tea_data = r_blk;
      end
      ST_WKLO: begin
        w_tea_we   = 1'b1;
        w_tea_addr = TEA_ADDR_KLO;
        w_tea_data = r_key[WORD_SIZE-1:0];
      end
      ST_WKHI: begin
        w_tea_we   = 1'b1;
        w_tea_addr = TEA_ADDR_KHI;
        w_tea_data = r_key[2*WORD_SIZE-1:WORD_SIZE];
      end
      ST_WCTL: begin
        w_tea_we   = 1'b1;
        w_tea_addr = TEA_ADDR_CTRL;
        w_tea_data = r_mode ? WORD_SIZE'(TEA_CMD_DEC) : WORD_SIZE'(TEA_CMD_ENC);
      end
      ST_RADR, ST_RCAP: w_tea_addr = TEA_ADDR_RES;
      default: ;
    endcase
    if (w_timeout)
      w_tea_rstn = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_tea_rstn  <= 1'b0;
      r_tea_addr  <= '0;
      r_tea_data  <= '0;
      r_tea_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_blk       <= '0;
      r_key       <= '0;
      r_mode      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_OUT);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_tea_rstn  <= w_tea_rstn;
      r_tea_addr  <= w_tea_addr;
      r_tea_data  <= w_tea_data;
      r_tea_we    <= w_tea_we;
      if (r_state == ST_RCAP)
        r_out_data <= bus.i_tea_data;
      if (w_accept) begin
        r_blk  <= bus.i_in_data;
        r_key  <= bus.i_key;
        r_mode <= bus.i_in_mode;
      end
    end
  end

`ifdef TEA_HOST_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_err;

  // Fires on the last allowed WAIT cycle so the block leaves after exactly TIMEOUT_CYCLES.
  assign w_timeout = (r_state == ST_WAIT) && !bus.i_tea_ready &&
                     (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT))
        r_wait_cnt <= r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign bus.o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_in_ready  = r_in_ready;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_data  = r_out_data;
  assign bus.o_tea_rstn  = r_tea_rstn;
  assign bus.o_tea_addr  = r_tea_addr;
  assign bus.o_tea_data  = r_tea_data;
  assign bus.o_tea_we    = r_tea_we;
  assign bus.o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tea_host_ctrl.sv
// ---------------------------------------------------------------------------
// Module : tb_tea_host_ctrl
// Brief  : Bench for tea_host_ctrl with a behavioural TEA core and TEA reference.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tea_host_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tea_host_ctrl_if #(.WORD_SIZE(64)) bus ();

  tea_host_ctrl #(.WORD_SIZE(64), .TIMEOUT_CYCLES(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [63:0] tea_enc(input logic [63:0] v, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = v[63:32]; v1 = v[31:0]; sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k[31:0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[63:32]));
      v1 = v1 + (((v0 << 4) + k[95:64]) ^ (v0 + sum) ^ ((v0 >> 5) + k[127:96]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] v, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = v[63:32]; v1 = v[31:0]; sum = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      v1 = v1 - (((v0 << 4) + k[95:64]) ^ (v0 + sum) ^ ((v0 >> 5) + k[127:96]));
      v0 = v0 - (((v1 << 4) + k[31:0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[63:32]));
      sum = sum - 32'h9E3779B9;
    end
    return {v0, v1};
  endfunction

  // Behavioural TEA core: registered reads, result ready core_lat cycles after control write.
  logic [63:0] c_data, c_klo, c_khi, c_res, c_rd;
  logic        c_ready;
  int          c_cnt;
  int          core_lat   = 0;
  bit          core_stuck = 1'b0;
  logic        force_ready = 1'b0;

  always @(posedge clk) begin
    if (!bus.o_tea_rstn) begin
      c_ready <= 1'b0;
      c_cnt   <= 0;
      c_rd    <= 64'd0;
    end else begin
      c_rd <= (bus.o_tea_addr == 3'd4) ? c_res : 64'd0;
      if (c_cnt != 0) begin
        c_cnt <= c_cnt - 1;
        if (c_cnt == 1 && !core_stuck) c_ready <= 1'b1;
      end
      if (bus.o_tea_we) begin
        case (bus.o_tea_addr)
          3'd0: c_data <= bus.o_tea_data;
          3'd1: c_klo  <= bus.o_tea_data;
          3'd2: c_khi  <= bus.o_tea_data;
          3'd3: begin
            c_res <= (bus.o_tea_data == 64'd2) ? tea_dec(c_data, {c_khi, c_klo})
                                               : tea_enc(c_data, {c_khi, c_klo});
            c_ready <= (core_lat == 0) && !core_stuck;
            c_cnt   <= core_lat;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.i_tea_data  = c_rd;
  assign bus.i_tea_ready = c_ready | force_ready;

  // Core-side event log: kind 8 = core held in reset, otherwise the write address.
  typedef struct { logic [3:0] kind; logic [63:0] data; } ev_t;
  ev_t log_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (!bus.o_tea_rstn)   log_q.push_back('{4'd8, 64'd0});
      else if (bus.o_tea_we) log_q.push_back('{{1'b0, bus.o_tea_addr}, bus.o_tea_data});
    end
  end

  typedef struct {
    logic [63:0]  data;
    logic [127:0] key;
    logic         mode;
    int           lat;
    bit           ign;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string tag, input logic [63:0] d, input logic [127:0] k, input logic m);
    logic [67:0] exp_ev[5];
    exp_ev[0] = {4'd8, 64'd0};
    exp_ev[1] = {4'd0, d};
    exp_ev[2] = {4'd1, k[63:0]};
    exp_ev[3] = {4'd2, k[127:64]};
    exp_ev[4] = {4'd3, m ? 64'd2 : 64'd1};
    chk({tag, "_log_len"}, log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++)
      chk($sformatf("%s_log%0d", tag, i), {log_q[i].kind, log_q[i].data}, exp_ev[i]);
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    while (!bus.o_in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk({tag, "_accept_timeout"}, 0, 1);
    tick();
  endtask

  task automatic run_block(input string tag, input vec_t v);
    int n;
    log_q.delete();
    core_lat = v.lat;
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = v.data;
    bus.i_key      = v.key;
    bus.i_in_mode  = v.mode;
    wait_accept(tag);
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = ~v.data;
    bus.i_key      = ~v.key;
    bus.i_in_mode  = ~v.mode;
    if (v.ign) force_ready = 1'b1;
    chk({tag, "_crst"}, {bus.o_busy, bus.o_in_ready, bus.o_tea_rstn}, 3'b100);
    n = 0;
    while (!bus.o_out_valid && n < 200) begin
      tick(); n++;
      if (n == 4) force_ready = 1'b0;
    end
    force_ready = 1'b0;
    chk({tag, "_latency"}, n, 8 + v.lat);
    chk({tag, "_out_data"}, bus.o_out_data, v.exp);
    chk_log(tag, v.data, v.key, v.mode);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
    chk({tag, "_post_hs"}, {bus.o_out_valid, bus.o_in_ready, bus.o_busy}, 3'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]  p0, p2, c0;
    logic [127:0] k0, k2;
    int n;

    p0 = 64'hDEADBEAF_BEBACAFE;
    k0 = 128'h00000004_00000003_00000002_00000001;
    c0 = tea_enc(p0, k0);
    vecs[0] = '{p0, k0, 1'b0, 0, 1'b0, c0};
    vecs[1] = '{c0, k0, 1'b1, 3, 1'b0, p0};
    vecs[2] = '{64'd0, {128{1'b1}}, 1'b0, 12, 1'b1, tea_enc(64'd0, {128{1'b1}})};
    vecs[3] = '{64'h01234567_89ABCDEF, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 1'b1, 5, 1'b0,
                tea_dec(64'h01234567_89ABCDEF, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0)};

    bus.i_in_valid  = 1'b0;
    bus.i_in_data   = '0;
    bus.i_in_mode   = 1'b0;
    bus.i_key       = '0;
    bus.i_out_ready = 1'b0;

    repeat (3) tick();
    chk("reset_ctrl", {bus.o_in_ready, bus.o_out_valid, bus.o_tea_rstn, bus.o_tea_we,
                       bus.o_busy, bus.o_err, bus.o_tea_addr}, 9'd0);
    chk("reset_data", {bus.o_out_data, bus.o_tea_data}, 128'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", bus.o_in_ready, 1'b1);

    for (int i = 0; i < 4; i++) run_block($sformatf("vec%0d", i), vecs[i]);

    // Backpressure, then back-to-back accept with a key changed at the handshake.
    p2 = 64'h55AA00FF_1234ABCD;
    k2 = 128'h11111111_22222222_33333333_44444444;
    log_q.delete();
    core_lat = 2;
    bus.i_in_valid = 1'b1; bus.i_in_data = p0; bus.i_key = k0; bus.i_in_mode = 1'b0;
    wait_accept("bp");
    bus.i_in_data = vecs[3].data; bus.i_key = vecs[3].key; bus.i_in_mode = 1'b1;
    n = 0;
    while (!bus.o_out_valid && n < 200) begin tick(); n++; end
    chk("bp_valid_seen", bus.o_out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i), {bus.o_out_valid, bus.o_in_ready, bus.o_out_data},
          {2'b10, c0});
      tick();
    end
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
    bus.i_in_data = p2; bus.i_key = k2; bus.i_in_mode = 1'b0;
    log_q.delete();
    chk("b2b_idle", {bus.o_in_ready, bus.o_out_valid}, 2'b10);
    tick();
    chk("b2b_accepted", {bus.o_busy, bus.o_in_ready}, 2'b10);
    bus.i_in_valid = 1'b0;
    n = 0;
    while (!bus.o_out_valid && n < 200) begin tick(); n++; end
    chk("b2b_out_data", bus.o_out_data, tea_enc(p2, k2));
    chk_log("b2b", p2, k2, 1'b0);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;

    // Reset while the core is computing.
    log_q.delete();
    core_lat = 30;
    bus.i_in_valid = 1'b1; bus.i_in_data = p0; bus.i_key = k0; bus.i_in_mode = 1'b0;
    wait_accept("rst");
    bus.i_in_valid = 1'b0;
    repeat (7) tick();
    chk("rst_in_wait", {bus.o_busy, bus.o_tea_we}, 2'b10);
    rst = 1'b1;
    tick();
    chk("rst_mid_op", {bus.o_busy, bus.o_out_valid, bus.o_tea_rstn, bus.o_in_ready}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("rst_idle", bus.o_in_ready, 1'b1);
    run_block("after_rst", vecs[1]);

`ifdef TEA_HOST_TIMEOUT_EN
    begin
      int lows;
      bit ov;
      core_stuck = 1'b1;
      core_lat   = 0;
      bus.i_in_valid = 1'b1; bus.i_in_data = p0; bus.i_key = k0; bus.i_in_mode = 1'b0;
      wait_accept("to");
      bus.i_in_valid = 1'b0;
      lows = bus.o_tea_rstn ? 0 : 1;
      ov = 1'b0;
      n = 0;
      while (bus.o_busy && n < 60) begin
        tick(); n++;
        if (!bus.o_tea_rstn) lows++;
        if (bus.o_out_valid) ov = 1'b1;
      end
      chk("to_cycles", n, 13);
      chk("to_err_idle", {bus.o_err, bus.o_in_ready, ov}, 3'b110);
      chk("to_rstn_pulses", lows, 2);
      core_stuck = 1'b0;
      tick();
      chk("to_rstn_release", bus.o_tea_rstn, 1'b1);
      run_block("after_to", vecs[0]);
      chk("to_err_sticky", bus.o_err, 1'b1);
    end
`else
    chk("err_tied_low", bus.o_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
